// File: rtl/chebyshev_sequencer.sv
// Control sequencer for an external Horner-style Chebyshev datapath: clears it, streams
// coefficients highest-first against a captured evaluation point, drains it, and holds the result.
module chebyshev_sequencer #(
  parameter int WL       = 16,
  parameter int CL       = 16,
  parameter int WIDENING = 3,
  parameter int DEGREE   = 7,
  parameter int AW       = 3,
  parameter int DRAIN    = 2,
  localparam int RW      = 2*WL + CL + WIDENING
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [WL-1:0] x_in,
  output logic                 busy,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic signed [CL-1:0] cfg_data,
  output logic                 dp_resetn,
  output logic signed [WL-1:0] dp_data,
  output logic signed [CL-1:0] dp_coeff,
  input  logic signed [RW-1:0] dp_result,
  output logic signed [RW-1:0] result,
  output logic                 result_valid,
  input  logic                 result_ready
);

  localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [AW:0] MAX_ADDR = (AW+1)'(DEGREE);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         k_q, k_d;
  logic [DCW-1:0]        dc_q, dc_d;
  logic signed [WL-1:0]  x_q, x_d;
  logic signed [CL-1:0]  coef_q [2**AW];
  logic                  coef_we;

  logic                  busy_q, busy_d;
  logic                  dp_resetn_q, dp_resetn_d;
  logic signed [WL-1:0]  dp_data_q, dp_data_d;
  logic signed [CL-1:0]  dp_coeff_q, dp_coeff_d;
  logic signed [RW-1:0]  result_q, result_d;
  logic                  result_valid_q, result_valid_d;

  // Coefficients are only writable while idle and inside 0..DEGREE.
  assign coef_we = cfg_we && (state_q == S_IDLE) && ({1'b0, cfg_addr} <= MAX_ADDR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**AW; i++) coef_q[i] <= '0;
    end else if (coef_we) begin
      coef_q[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      dc_q    <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dc_q    <= dc_d;
      x_q     <= x_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dc_d    = dc_q;
    x_d     = x_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          x_d     = x_in;
          k_d     = AW'(DEGREE);
        end
      end
      S_CLEAR: state_d = S_FEED;
      S_FEED: begin
        if (k_q == '0) begin
          state_d = S_DRAIN;
          dc_d    = DCW'(DRAIN - 1);
        end else begin
          k_d = k_q - AW'(1);
        end
      end
      S_DRAIN: begin
        if (dc_q == '0) state_d = S_HOLD;
        else            dc_d    = dc_q - DCW'(1);
      end
      S_HOLD: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port is a flop.
  always_comb begin
    busy_d         = (state_d != S_IDLE);
    dp_resetn_d    = (state_d != S_CLEAR);
    dp_data_d      = ((state_d == S_FEED) || (state_d == S_DRAIN)) ? x_q : '0;
    dp_coeff_d     = (state_d == S_FEED) ? coef_q[k_d] : '0;
    result_d       = ((state_q == S_DRAIN) && (dc_q == '0)) ? dp_result : result_q;
    result_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q         <= 1'b0;
      dp_resetn_q    <= 1'b0;
      dp_data_q      <= '0;
      dp_coeff_q     <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      dp_resetn_q    <= dp_resetn_d;
      dp_data_q      <= dp_data_d;
      dp_coeff_q     <= dp_coeff_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy         = busy_q;
  assign dp_resetn    = dp_resetn_q;
  assign dp_data      = dp_data_q;
  assign dp_coeff     = dp_coeff_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: doc/chebyshev_sequencer.md
CHEBYSHEV_SEQUENCER -- requirements
Module: chebyshev_sequencer

Interface
REQ-001 SHALL have parameter WL, default 16, data word length.
REQ-002 SHALL have parameter CL, default 16, coefficient word length.
REQ-003 SHALL have parameter WIDENING, default 3, accumulator guard bits; ceil(log2(DEGREE)).
REQ-004 SHALL have parameter DEGREE, default 7, polynomial degree; DEGREE+1 coefficients.
REQ-005 SHALL have parameter AW, default 3, coefficient address width; 2^AW >= DEGREE+1.
REQ-006 SHALL have parameter DRAIN, default 2, datapath flush cycles after the last coefficient.
REQ-007 SHALL define RW = 2*WL+CL+WIDENING, the result width.
REQ-008 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-009 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-010 SHALL have port start  input  1  evaluation request; sampled only in IDLE.
REQ-011 SHALL have port x_in  input  WL  evaluation point (signed); captured with accepted start.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port cfg_we  input  1  coefficient write strobe.
REQ-014 SHALL have port cfg_addr  input  AW  coefficient index 0..DEGREE.
REQ-015 SHALL have port cfg_data  input  CL  coefficient value (signed).
REQ-016 SHALL have port dp_resetn  output  1  active-low clear of the datapath.
REQ-017 SHALL have port dp_data  output  WL  datapath data operand.
REQ-018 SHALL have port dp_coeff  output  CL  datapath coefficient operand.
REQ-019 SHALL have port dp_result  input  RW  datapath accumulator value.
REQ-020 SHALL have port result  output  RW  captured evaluation result.
REQ-021 SHALL have port result_valid  output  1  result available.
REQ-022 SHALL have port result_ready  input  1  consumer accepts result.

Function
REQ-023 SHALL implement FSM states IDLE, CLEAR, FEED, DRAIN, HOLD; all outputs registered.
REQ-024 IDLE: start=1 (cycle 0) SHALL capture x_in into x_reg and enter CLEAR; start outside IDLE SHALL be ignored.
REQ-025 CLEAR (cycle 1): dp_resetn=0, dp_data=0, dp_coeff=0; load counter k=DEGREE; next FEED.
REQ-026 FEED: cycles 2..DEGREE+2; dp_data=x_reg, dp_coeff=coef[k], k decrements per cycle (order DEGREE down to 0); after k=0 enter DRAIN.
REQ-027 DRAIN: cycles DEGREE+3..DEGREE+2+DRAIN; dp_data=x_reg, dp_coeff=0; on last DRAIN cycle capture dp_result into result; enter HOLD.
REQ-028 HOLD: result_valid=1 from cycle DEGREE+3+DRAIN; result stable until result_ready=1, then result_valid=0 and IDLE next cycle.
REQ-029 dp_resetn SHALL be 1 in every state except CLEAR and except while reset is asserted.
REQ-030 cfg_we SHALL write coef[cfg_addr] only in IDLE; writes in other states or with cfg_addr>DEGREE SHALL be ignored.
REQ-031 cfg_we and accepted start in the same cycle: write SHALL take effect and be used by that evaluation.
REQ-032 result_ready with start in HOLD: handshake completes, start ignored; start accepted no earlier than next cycle (IDLE).
REQ-033 result_ready outside HOLD SHALL have no effect; result retains last captured value.

Reset
REQ-034 reset=1 SHALL immediately force IDLE, busy=0, result_valid=0, result=0, dp_resetn=0, dp_data=0, dp_coeff=0, k=0, x_reg=0, all coef[]=0; mid-evaluation reset aborts with no result.

Verification (WL=8, CL=8, WIDENING=2, DEGREE=3, AW=2, DRAIN=2, datapath stub)
REQ-035 Load coef[0..3]={5,-3,7,1}, start x_in=0x10 at cycle 0 -> dp_resetn=0 cycle 1; dp_coeff=1,7,-3,5 cycles 2-5 with dp_data=0x10; dp_coeff=0 cycles 6-7; result_valid=1 cycle 8, result=dp_result at cycle 7.
REQ-036 Hold result_ready=0 for 10 cycles with start pulses -> result, result_valid, busy=1 unchanged, no new evaluation; result_ready=1 -> result_valid=0 and busy=0 next cycle.
REQ-037 cfg_we addr 2 data 0x55 during FEED, and addr 3 data 0x7F in IDLE with DEGREE=2 build -> both ignored; next evaluation uses prior values.
REQ-038 start with cfg_we addr 3 data 9 same cycle -> first FEED dp_coeff=9.
REQ-039 reset=1 in FEED cycle 3 -> same-cycle busy=0, dp_resetn=0, result_valid=0; after release, evaluation issues dp_coeff=0 for all coefficients.
REQ-040 result_ready=1 and start=1 together in HOLD -> start ignored; start next cycle accepted, CLEAR one cycle later.
